// File: rtl/hilo_mdu_ctrl_if.sv
`default_nettype none
//============================================================================
// Module : hilo_mdu_ctrl_if
// Brief  : EX-stage <-> multiply/divide unit request/response bundle
// Rev    : 1.0  initial release
//============================================================================
interface hilo_mdu_ctrl_if;
   logic        flush;
   logic        ex_stall;
   logic        op_valid;
   logic [8:0]  hilo_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        stallreq;
   logic [31:0] hilo_rdata;
   logic        busy;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   modport master (
      output flush, ex_stall, op_valid, hilo_op, src_a, src_b,
      input  stallreq, hilo_rdata, busy, hi_o, lo_o
   );

   modport slave (
      input  flush, ex_stall, op_valid, hilo_op, src_a, src_b,
      output stallreq, hilo_rdata, busy, hi_o, lo_o
   );
endinterface
`default_nettype wire

// File: rtl/hilo_mdu_ctrl.sv
`default_nettype none
//============================================================================
// Module : hilo_mdu_ctrl
// Brief  : Iterative multiply/divide sequencer and HI/LO register owner
// Rev    : 1.0  initial release
//============================================================================
module hilo_mdu_ctrl #(
   parameter int FAST_MUL = 0,
   parameter int ITER     = 32
) (
   input  wire            clk,
   input  wire            rst,
   hilo_mdu_ctrl_if.slave bus
);

   localparam int                 c_cnt_w = $clog2(ITER);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [31:0]         r_hi, r_lo;
   logic [31:0]         r_acc_hi, r_acc_lo, r_opnd;
   logic [c_cnt_w-1:0]  r_count;
   logic                r_is_div, r_is_mul, r_neg_q, r_neg_r;

   logic w_mfhi, w_mflo, w_mthi, w_mtlo, w_mult, w_multu, w_div, w_divu, w_mul;
   logic w_mult_any, w_div_any, w_signed, w_start, w_fast, w_start_mc, w_fast_go;
   logic [31:0] w_abs_a, w_abs_b;
   logic [63:0] w_fast_prod, w_prod;
   logic [31:0] w_quot, w_rem;
   logic [32:0] w_add, w_shl;
   logic [31:0] w_sub;
   logic        w_qbit;

   assign {w_mfhi, w_mflo, w_mthi, w_mtlo, w_mult, w_multu, w_div, w_divu, w_mul} = bus.hilo_op;

   assign w_mult_any = w_mult | w_multu | w_mul;
   assign w_div_any  = w_div | w_divu;
   assign w_signed   = w_mult | w_mul | w_div;
   assign w_start    = bus.op_valid & (w_mult_any | w_div_any) & ~bus.flush;
   assign w_start_mc = w_start & ~w_fast & (r_state == S_IDLE);
   assign w_fast_go  = w_start & w_fast & (r_state == S_IDLE);

   generate
      if (FAST_MUL != 0) begin : g_fast_mul
         logic [63:0] w_ext_a, w_ext_b;
         assign w_ext_a     = {{32{w_signed & bus.src_a[31]}}, bus.src_a};
         assign w_ext_b     = {{32{w_signed & bus.src_b[31]}}, bus.src_b};
         assign w_fast_prod = w_ext_a * w_ext_b;
         assign w_fast      = w_mult_any;
      end else begin : g_iter_mul
         assign w_fast_prod = 64'd0;
         assign w_fast      = 1'b0;
      end
   endgenerate

   assign w_abs_a = (w_signed & bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
   assign w_abs_b = (w_signed & bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;

   // Multiply: conditional add into the upper half, then shift the 64-bit pair right.
   assign w_add  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);
   // Divide: restoring step; partial remainder < divisor keeps the difference in 32 bits.
   assign w_shl  = {r_acc_hi, r_acc_lo[31]};
   assign w_qbit = (w_shl >= {1'b0, r_opnd});
   assign w_sub  = w_shl[31:0] - r_opnd;

   assign w_prod = r_neg_q ? (~{r_acc_hi, r_acc_lo} + 64'd1) : {r_acc_hi, r_acc_lo};
   assign w_quot = r_neg_q ? (~r_acc_lo + 32'd1) : r_acc_lo;
   assign w_rem  = r_neg_r ? (~r_acc_hi + 32'd1) : r_acc_hi;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_acc_hi <= 32'd0;
         r_acc_lo <= 32'd0;
         r_opnd   <= 32'd0;
         r_count  <= '0;
         r_is_div <= 1'b0;
         r_is_mul <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else if (bus.flush) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_mc) begin
                  r_acc_hi <= 32'd0;
                  r_acc_lo <= w_div_any ? w_abs_a : w_abs_b;
                  r_opnd   <= w_div_any ? w_abs_b : w_abs_a;
                  r_is_div <= w_div_any;
                  r_is_mul <= w_mul;
                  r_neg_q  <= w_signed & (bus.src_a[31] ^ bus.src_b[31]);
                  r_neg_r  <= w_div & bus.src_a[31];
                  r_count  <= '0;
                  r_state  <= S_CALC;
               end else if (w_fast_go & ~w_mul & ~bus.ex_stall) begin
                  {r_hi, r_lo} <= w_fast_prod;
               end else if (bus.op_valid & ~bus.ex_stall) begin
                  if (w_mthi) r_hi <= bus.src_a;
                  if (w_mtlo) r_lo <= bus.src_a;
               end
            end
            S_CALC: begin
               if (r_is_div) begin
                  r_acc_hi <= w_qbit ? w_sub : w_shl[31:0];
                  r_acc_lo <= {r_acc_lo[30:0], w_qbit};
               end else begin
                  {r_acc_hi, r_acc_lo} <= {w_add, r_acc_lo[31:1]};
               end
               r_count <= r_count + c_cnt_w'(1);
               if (r_count == c_last) r_state <= S_DONE;
            end
            S_DONE: begin
               // Held here while EX is stalled elsewhere so the instruction cannot restart.
               if (~bus.ex_stall) begin
                  if (r_is_div) begin
                     r_lo <= w_quot;
                     r_hi <= w_rem;
                  end else if (~r_is_mul) begin
                     {r_hi, r_lo} <= w_prod;
                  end
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.stallreq = ~bus.flush & ((r_state == S_CALC) | w_start_mc);
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.hi_o     = r_hi;
   assign bus.lo_o     = r_lo;

   always_comb begin
      bus.hilo_rdata = 32'd0;
      if ((r_state == S_DONE) && r_is_mul)
         bus.hilo_rdata = w_prod[31:0];
      else if (bus.op_valid) begin
         if (w_mfhi)
            bus.hilo_rdata = r_hi;
         else if (w_mflo)
            bus.hilo_rdata = r_lo;
         else if (w_fast_go & w_mul)
            bus.hilo_rdata = w_fast_prod[31:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hilo_mdu_ctrl.sv
`default_nettype none
//============================================================================
// Module : tb_hilo_mdu_ctrl
// Brief  : Scoreboard bench for hilo_mdu_ctrl, iterative and fast multiply builds
// Rev    : 1.0  initial release
//============================================================================
module tb_hilo_mdu_ctrl;

   localparam logic [8:0] OP_MFHI  = 9'h100;
   localparam logic [8:0] OP_MFLO  = 9'h080;
   localparam logic [8:0] OP_MTHI  = 9'h040;
   localparam logic [8:0] OP_MTLO  = 9'h020;
   localparam logic [8:0] OP_MULT  = 9'h010;
   localparam logic [8:0] OP_MULTU = 9'h008;
   localparam logic [8:0] OP_DIV   = 9'h004;
   localparam logic [8:0] OP_DIVU  = 9'h002;
   localparam logic [8:0] OP_MUL   = 9'h001;

   typedef struct {
      logic [8:0]  op;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] rd;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic [31:0] f_hi = 32'd0, f_lo = 32'd0;

   hilo_mdu_ctrl_if if0();
   hilo_mdu_ctrl_if if1();

   hilo_mdu_ctrl #(.FAST_MUL(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   hilo_mdu_ctrl #(.FAST_MUL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      assert ($onehot0(if0.hilo_op) && $onehot0(if1.hilo_op))
         else $error("illegal hilo_op encoding driven");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Reference model built on native arithmetic; division by zero follows the block's fixed rule.
   function automatic void ref_op(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] old_hi, input logic [31:0] old_lo,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic [31:0] rd);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = old_hi; lo = old_lo; rd = 32'd0;
      case (op)
         OP_MULT, OP_MUL: begin
            p = 64'(sa * sb);
            if (op == OP_MUL) rd = p[31:0];
            else {hi, lo} = p;
         end
         OP_MULTU: {hi, lo} = {32'd0, a} * {32'd0, b};
         OP_DIV: begin
            if (b == 32'd0) begin
               lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
               hi = a;
            end else begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; hi = r[31:0];
            end
         end
         OP_DIVU: begin
            if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
            else begin lo = a / b; hi = a % b; end
         end
         default: ;
      endcase
   endfunction

   task automatic mc_op(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n_hold);
      exp_t e;
      int   nst;
      bit   done;
      e.op = op;
      ref_op(op, a, b, m_hi, m_lo, e.hi, e.lo, e.rd);
      sb_q.push_back(e);
      @(negedge clk);
      if0.op_valid = 1'b1; if0.hilo_op = op; if0.src_a = a; if0.src_b = b; if0.ex_stall = 1'b0;
      nst = 0; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         #1;
         if (if0.stallreq) begin nst++; @(negedge clk); end
         else done = 1'b1;
      end
      check("done_reached", 32'(done), 32'd1);
      check("stall_cycles", 32'(nst), 32'd33);
      e = sb_q.pop_front();
      check("done_busy", 32'(if0.busy), 32'd1);
      if (e.op == OP_MUL) check("mul_rdata", if0.hilo_rdata, e.rd);
      if (n_hold > 0) begin
         if0.ex_stall = 1'b1;
         repeat (n_hold) begin
            @(negedge clk); #1;
            check("hold_stallreq", 32'(if0.stallreq), 32'd0);
            check("hold_busy", 32'(if0.busy), 32'd1);
            check("hold_hi", if0.hi_o, m_hi);
            check("hold_lo", if0.lo_o, m_lo);
         end
         if0.ex_stall = 1'b0;
      end
      @(negedge clk);
      if0.op_valid = 1'b0; if0.hilo_op = 9'd0;
      #1;
      check("after_busy", 32'(if0.busy), 32'd0);
      check("commit_hi", if0.hi_o, e.hi);
      check("commit_lo", if0.lo_o, e.lo);
      m_hi = e.hi; m_lo = e.lo;
   endtask

   task automatic rd_op(input string tag, input logic [8:0] op, input logic [31:0] exp);
      @(negedge clk);
      if0.op_valid = 1'b1; if0.hilo_op = op; if0.ex_stall = 1'b0;
      #1;
      check(tag, if0.hilo_rdata, exp);
      check({tag, "_nostall"}, 32'(if0.stallreq), 32'd0);
   endtask

   task automatic wr_op(input logic [8:0] op, input logic [31:0] a);
      @(negedge clk);
      if0.op_valid = 1'b1; if0.hilo_op = op; if0.src_a = a; if0.ex_stall = 1'b0;
      #1;
      check("mtx_nostall", 32'(if0.stallreq), 32'd0);
      if (op == OP_MTHI) m_hi = a; else m_lo = a;
   endtask

   task automatic fast_op(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit stall_first);
      exp_t e;
      e.op = op;
      ref_op(op, a, b, f_hi, f_lo, e.hi, e.lo, e.rd);
      sb_q.push_back(e);
      @(negedge clk);
      if1.op_valid = 1'b1; if1.hilo_op = op; if1.src_a = a; if1.src_b = b;
      if1.ex_stall = stall_first;
      #1;
      check("fast_stallreq", 32'(if1.stallreq), 32'd0);
      check("fast_busy", 32'(if1.busy), 32'd0);
      if (op == OP_MUL) check("fast_mul_rdata", if1.hilo_rdata, e.rd);
      if (stall_first) begin
         @(negedge clk); #1;
         check("fast_held_hi", if1.hi_o, f_hi);
         check("fast_held_lo", if1.lo_o, f_lo);
         if1.ex_stall = 1'b0;
      end
      @(negedge clk);
      if1.op_valid = 1'b0; if1.hilo_op = 9'd0;
      #1;
      e = sb_q.pop_front();
      check("fast_hi", if1.hi_o, e.hi);
      check("fast_lo", if1.lo_o, e.lo);
      f_hi = e.hi; f_lo = e.lo;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] rop;
      rst = 1'b1;
      if0.flush = 1'b0; if0.ex_stall = 1'b0; if0.op_valid = 1'b0; if0.hilo_op = 9'd0;
      if0.src_a = 32'd0; if0.src_b = 32'd0;
      if1.flush = 1'b0; if1.ex_stall = 1'b0; if1.op_valid = 1'b0; if1.hilo_op = 9'd0;
      if1.src_a = 32'd0; if1.src_b = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_hi", if0.hi_o, 32'd0);
      check("rst_lo", if0.lo_o, 32'd0);
      check("rst_busy", 32'(if0.busy), 32'd0);
      check("rst_stallreq", 32'(if0.stallreq), 32'd0);
      check("rst_rdata", if0.hilo_rdata, 32'd0);

      mc_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0);
      rd_op("mflo_after_mult", OP_MFLO, 32'hFFFF_FFF1);
      mc_op(OP_DIVU, 32'd100, 32'd7, 0);
      mc_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      mc_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      mc_op(OP_DIVU, 32'd5, 32'd0, 0);
      mc_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0);
      mc_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      mc_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 3);
      mc_op(OP_MUL, 32'd6, 32'd7, 0);
      for (int i = 0; i < 4; i++) begin
         rop = OP_MULT >> $urandom_range(0, 3);
         mc_op(rop, $urandom, $urandom, 0);
      end

      // Flush at CALC counter 10: start cycle plus ten iterations.
      @(negedge clk);
      if0.op_valid = 1'b1; if0.hilo_op = OP_DIV; if0.src_a = 32'd100; if0.src_b = 32'd3;
      repeat (11) @(negedge clk);
      if0.flush = 1'b1;
      #1;
      check("flush_stallreq", 32'(if0.stallreq), 32'd0);
      @(negedge clk);
      if0.flush = 1'b0; if0.op_valid = 1'b0; if0.hilo_op = 9'd0;
      #1;
      check("flush_busy", 32'(if0.busy), 32'd0);
      check("flush_hi", if0.hi_o, m_hi);
      check("flush_lo", if0.lo_o, m_lo);
      mc_op(OP_DIVU, 32'd100, 32'd7, 0);

      wr_op(OP_MTHI, 32'h0000_1234);
      rd_op("mflo_b2b", OP_MFLO, m_lo);
      rd_op("mfhi_b2b", OP_MFHI, 32'h0000_1234);
      wr_op(OP_MTLO, 32'hCAFE_F00D);
      rd_op("mflo_after_mtlo", OP_MFLO, 32'hCAFE_F00D);
      @(negedge clk);
      if0.op_valid = 1'b0; if0.hilo_op = 9'd0;

      fast_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
      fast_op(OP_MUL, 32'd6, 32'd7, 1'b0);
      fast_op(OP_MULTU, $urandom, $urandom, 1'b1);
      fast_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);

      // Reset in the middle of an iterative operation.
      @(negedge clk);
      if0.op_valid = 1'b1; if0.hilo_op = OP_MULTU; if0.src_a = 32'd9; if0.src_b = 32'd9;
      repeat (5) @(negedge clk);
      rst = 1'b1; if0.op_valid = 1'b0; if0.hilo_op = 9'd0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_busy", 32'(if0.busy), 32'd0);
      check("midrst_hi", if0.hi_o, 32'd0);
      check("midrst_lo", if0.lo_o, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage of the 5-stage MIPS pipeline.
- Accepts the 9-bit hilo_op vector decoded in ID, together with the forwarded rs/rt operands.
- Runs an iterative shift-add multiplier or restoring divider, holds the pipeline through stallreq until the result is ready, then commits HI/LO.
- Serves mfhi/mflo/mul results back to EX.

Parameters:
- FAST_MUL, 0: 1 = mult/multu/mul complete combinationally in one cycle with no stall; 0 = 32-iteration shift-add.
- ITER, 32: iterations per multi-cycle operation; fixed by 32-bit operands and not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  abort any in-flight operation; no HI/LO update
- ex_stall  in  1  EX held by another stall source this cycle
- op_valid  in  1  EX holds a valid instruction
- hilo_op  in  9  {mfhi,mflo,mthi,mtlo,mult,multu,div,divu,mul}, one-hot or zero
- src_a  in  32  rs value (dividend / multiplicand / mthi-mtlo data)
- src_b  in  32  rt value (divisor / multiplier)
- stallreq  out  1  request to hold IF..EX
- hilo_rdata  out  32  mfhi → HI, mflo → LO, mul → low product word, otherwise 0
- busy  out  1  state != IDLE
- hi_o  out  32  current HI (debug / WB observation)
- lo_o  out  32  current LO (debug / WB observation)

Behaviour:
- Reset values: state=IDLE, HI=0, LO=0, counter=0, stallreq=0, busy=0, hilo_rdata=0.
- States: IDLE, CALC, DONE.
- start = op_valid & (mult|multu|div|divu|mul) & ~flush.

IDLE:
- On start (FAST_MUL=0, or any div): latch |a|, |b| (signed ops) or raw values (unsigned), plus result sign flags. Clear counter, go to CALC.
- stallreq=1 combinationally in this start cycle.
- FAST_MUL=1 and a multiply: the product is computed this cycle with stallreq=0.
  - mult/multu commit {HI,LO} at the edge if ~ex_stall.
  - mul drives hilo_rdata; HI/LO are not written.

CALC:
- One iteration per cycle, counter 0..ITER-1; stallreq=1.
- At counter==ITER-1, go to DONE.

DONE:
- stallreq=0; the final result is valid.
- mul: hilo_rdata = low 32 bits of the product.
- If ~ex_stall: commit HI/LO at the clock edge and go to IDLE.
  - mult/multu: {HI,LO} = 64-bit product.
  - div/divu: LO = quotient, HI = remainder.
  - mul: no commit.
- If ex_stall: hold DONE with the result stable, no commit yet. The held instruction must not restart.

Latency:
- A multi-cycle op occupies EX for 1 (start) + ITER (CALC) + 1 (DONE) = 34 cycles minimum.
- stallreq is high for exactly 33 of those cycles.

Arithmetic:
- Signed ops take operand magnitudes. Signed results are fixed up after the iterations:
  - product negated if a[31]^b[31];
  - quotient negated if a[31]^b[31];
  - remainder takes the sign of the dividend.
- Division by zero is deterministic:
  - divu: LO=0xFFFFFFFF, HI=a.
  - div: LO=0xFFFFFFFF if a>=0, else 0x00000001; HI=a.
- div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.

mthi/mtlo:
- Accepted only in IDLE, when op_valid & ~ex_stall & ~flush.
- Write HI (or LO) = src_a at the edge; no stall.

mfhi/mflo:
- Combinational read of the registered HI/LO.
- A commit completed on an earlier edge is visible to the next instruction in EX. No internal forwarding of a same-cycle write.

flush:
- In any state: next state IDLE, counter cleared, stallreq=0 in that cycle, no HI/LO write.
- flush has priority over start and commit.

rst:
- Mid-operation rst behaves like flush and also clears HI/LO.

Illegal input:
- hilo_op with more than one bit set is illegal; the block behaviour is unspecified, and the bench asserts it never occurs.

Test Plan:
- mult, a=0xFFFFFFFD (-3), b=5, FAST_MUL=0 → stallreq high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; a following mflo returns 0xFFFFFFF1.
- divu 100/7 → LO=14, HI=2 after 34 cycles. div -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. divu 5/0 → LO=0xFFFFFFFF, HI=5. div 0xFFFFFFF9 (-7)/0 → LO=0x00000001, HI=0xFFFFFFF9.
- Start div, assert flush at CALC counter=10 → IDLE next cycle, stallreq=0, HI/LO unchanged. A new divu starts cleanly on the following cycle.
- mult completes while ex_stall=1 for 3 cycles in DONE → state stays DONE, no restart, stallreq=0. HI/LO are written only on the first cycle with ex_stall=0.
- mthi 0x1234 then mflo/mfhi back-to-back → mfhi returns 0x1234 on the next cycle. mul 6*7 → hilo_rdata=42 in DONE, HI/LO unchanged. Repeat the multiply cases with FAST_MUL=1 → zero stall cycles.
